// File: rtl/i2c_master_gen.sv
// I2C master: N-byte write, read, or write + repeated-start read; open-drain SCL/SDA.
// Optional slave clock stretching is compiled in with `define I2C_CLK_STRETCH_EN.
module i2c_master_gen #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CLK_DIV   = 4,
  localparam int unsigned CW       = $clog2(MAX_BYTES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   rw_i,
  input  logic                   rep_i,
  input  logic [CW-1:0]          bytcount_i,
  input  logic [6:0]             addr_i,
  input  logic [8*MAX_BYTES-1:0] din_i,
  output logic [8*MAX_BYTES-1:0] dout_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   nack_o,
  output logic [3:0]             istate_o,
  inout  wire                    i2c_scl_io,
  inout  wire                    i2c_sda_io
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StStart  = 4'd1,
    StAddr   = 4'd2,
    StAack   = 4'd3,
    StWdata  = 4'd4,
    StWack   = 4'd5,
    StRstart = 4'd6,
    StRaddr  = 4'd7,
    StRdata  = 4'd8,
    StRack   = 4'd9,
    StStop   = 4'd10
  } state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [1:0]             phase_q, phase_d;
  logic [3:0]             bit_q, bit_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [6:0]             addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   rep_q, rep_d;
  logic [8*MAX_BYTES-1:0] din_q, din_d;
  logic [8*MAX_BYTES-1:0] dout_q, dout_d;
  logic [7:0]             shift_q, shift_d;
  logic                   ack_q, ack_d;
  logic                   nack_q, nack_d;
  logic                   done_q, done_d;
  logic                   scl_low_q, scl_low_d;
  logic                   sda_pre_q, sda_low_q, sda_low_d;

  logic       qt, stall, step, sample, bit_end, lo_ph, sda_in, dir;
  logic [7:0] abyte, rbyte, wbyte;

  assign sda_in = i2c_sda_io;
  assign qt     = (div_q == DivLast);

`ifdef I2C_CLK_STRETCH_EN
  // Hold the Q2->Q3 boundary while a slave keeps SCL low.
  assign stall = qt && (phase_q == 2'd2) && (i2c_scl_io !== 1'b1);
`else
  assign stall = 1'b0;
`endif

  assign step    = qt && !stall && (state_q != StIdle);
  assign sample  = step && (phase_q == 2'd2);
  assign bit_end = step && (phase_q == 2'd3);
  assign lo_ph   = ~phase_q[1];
  assign dir     = rw_q & ~rep_q;
  assign abyte   = {addr_q, dir};
  assign rbyte   = {addr_q, 1'b1};
  assign wbyte   = din_q[8*(MAX_BYTES-1-32'(idx_q)) +: 8];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    rep_d   = rep_q;
    din_d   = din_q;
    dout_d  = dout_q;
    shift_d = shift_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    if (state_q != StIdle) begin
      if (!stall) div_d = qt ? '0 : div_q + DW'(1);
      if (step) phase_d = phase_q + 2'd1;
    end
    if (sample) begin
      ack_d   = sda_in;
      shift_d = {shift_q[6:0], sda_in};
    end
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          addr_d  = addr_i;
          rw_d    = rw_i;
          rep_d   = rep_i & rw_i;
          cnt_d   = bytcount_i;
          din_d   = din_i;
          dout_d  = '0;
          nack_d  = 1'b0;
          idx_d   = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: if (bit_end) state_d = StAddr;
      StAddr: begin
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            bit_d   = '0;
            state_d = StAack;
          end
        end
      end
      StAack: begin
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            state_d = dir ? StRdata : StWdata;
          end
        end
      end
      StWdata: begin
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            bit_d   = '0;
            state_d = StWack;
          end
        end
      end
      StWack: begin
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (idx_q < cnt_q) begin
            idx_d   = idx_q + CW'(1);
            state_d = StWdata;
          end else if (rep_q) begin
            idx_d   = '0;
            state_d = StRstart;
          end else begin
            state_d = StStop;
          end
        end
      end
      StRstart: if (bit_end) state_d = StRaddr;
      StRaddr: begin
        // Bits 0..7 carry {addr,1}; bit 8 is the slave's acknowledge slot.
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            bit_d = '0;
            if (ack_q) begin
              nack_d  = 1'b1;
              state_d = StStop;
            end else begin
              state_d = StRdata;
            end
          end
        end
      end
      StRdata: begin
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            bit_d = '0;
            dout_d[8*(MAX_BYTES-1-32'(idx_q)) +: 8] = shift_q;
            state_d = StRack;
          end
        end
      end
      StRack: begin
        if (bit_end) begin
          if (idx_q < cnt_q) begin
            idx_d   = idx_q + CW'(1);
            state_d = StRdata;
          end else begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StStart: sda_low_d = 1'b1;
      StAddr: begin
        scl_low_d = lo_ph;
        sda_low_d = ~abyte[3'd7 - bit_q[2:0]];
      end
      StAack:  scl_low_d = lo_ph;
      StWdata: begin
        scl_low_d = lo_ph;
        sda_low_d = ~wbyte[3'd7 - bit_q[2:0]];
      end
      StWack:  scl_low_d = lo_ph;
      StRstart: begin
        scl_low_d = lo_ph;
        sda_low_d = (phase_q == 2'd3);
      end
      StRaddr: begin
        scl_low_d = lo_ph;
        sda_low_d = ~bit_q[3] & ~rbyte[3'd7 - bit_q[2:0]];
      end
      StRdata: scl_low_d = lo_ph;
      StRack: begin
        scl_low_d = lo_ph;
        sda_low_d = (idx_q < cnt_q);
      end
      StStop: begin
        scl_low_d = lo_ph;
        sda_low_d = (phase_q != 2'd3);
      end
      default: ;
    endcase
  end

  // SDA lags SCL by one extra clk so data edges never coincide with SCL edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      rep_q     <= 1'b0;
      din_q     <= '0;
      dout_q    <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_low_q <= 1'b0;
      sda_pre_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      rep_q     <= rep_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      scl_low_q <= scl_low_d;
      sda_pre_q <= sda_low_d;
      sda_low_q <= sda_pre_q;
    end
  end

  assign i2c_scl_io = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda_io = sda_low_q ? 1'b0 : 1'bz;
  assign dout_o     = dout_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign nack_o     = nack_q;
  assign istate_o   = state_q;

endmodule
